// File: rtl/jt5205_pkg.sv
// jt5205_pkg: MSM5205 ADPCM constants shared by the jt5205 encoder and decoder
// Contents: encoder FSM states, 49-entry step table, index adaptation, PCM and index limits.
package jt5205_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_Q2, ST_Q1, ST_Q0, ST_UPD} enc_state_t;
  localparam int IDX_MAX = 48;
  localparam int PCM_MIN = -2048;
  localparam int PCM_MAX = 2047;
  localparam logic [10:0] STEP_TBL [0:48] = '{
    11'd16,   11'd17,   11'd19,   11'd21,   11'd23,   11'd25,   11'd28,   11'd31,
    11'd34,   11'd37,   11'd41,   11'd45,   11'd50,   11'd55,   11'd60,   11'd66,
    11'd73,   11'd80,   11'd88,   11'd97,   11'd107,  11'd118,  11'd130,  11'd143,
    11'd157,  11'd173,  11'd190,  11'd209,  11'd230,  11'd253,  11'd279,  11'd307,
    11'd337,  11'd371,  11'd408,  11'd449,  11'd494,  11'd544,  11'd598,  11'd658,
    11'd724,  11'd796,  11'd876,  11'd963,  11'd1060, 11'd1166, 11'd1282, 11'd1411,
    11'd1552};
  localparam logic signed [4:0] IDX_ADJ [0:7] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1, 5'sd2, 5'sd4, 5'sd6, 5'sd8};
endpackage

// File: rtl/jt5205_enc_step.sv
// jt5205_enc_step: combinational step-size ROM indexed by the adaptation index
// Ports: i_idx (6b step index, 0..48), o_step (11b step size).
module jt5205_enc_step
  import jt5205_pkg::*;
(
  input  logic [5:0]  i_idx,
  output logic [10:0] o_step
);
  // Indices beyond the table never occur; clamp so the ROM has no undefined entries.
  assign o_step = i_idx > 6'(IDX_MAX) ? STEP_TBL[IDX_MAX] : STEP_TBL[i_idx];
endmodule

// File: rtl/jt5205_enc.sv
// jt5205_enc: MSM5205-compatible 4-bit ADPCM encoder, one bit-serial pass per sample
// Ports: clk, rst (sync active-high), cen (clock enable), restart (new stream),
//   din[11:0]/din_valid/din_ready (PCM in), dout[3:0]/dout_valid/dout_ready (code out).
// Option JT5205_ENC_RECON_EN adds recon[11:0] (decoder-reproduced sample) and step_idx[5:0].
module jt5205_enc
  import jt5205_pkg::*;
#(
  parameter int INIT_IDX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        restart,
  input  logic [11:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [3:0]  dout,
  output logic        dout_valid,
  input  logic        dout_ready
`ifdef JT5205_ENC_RECON_EN
  ,
  output logic signed [11:0] recon,
  output logic [5:0]         step_idx
`endif
);
  enc_state_t         r_state, w_state_nx;
  logic signed [11:0] r_pred, w_pred_nx;
  logic [5:0]         r_idx, w_idx_nx;
  logic [11:0]        r_mag, w_mag_in, w_thr, w_delta;
  logic [2:0]         r_bits;
  logic [3:0]         r_dout;
  logic               r_sign, r_dout_valid, w_hit, w_in_xfer, w_out_free, w_upd;
  logic [10:0]        w_step;
  logic [12:0]        w_diff;
  logic [13:0]        w_dext;
  logic signed [13:0] w_pred_sum;
  logic signed [6:0]  w_idx_sum;
  jt5205_enc_step u_step (.i_idx(r_idx), .o_step(w_step));
  always_comb begin
    din_ready  = r_state == ST_IDLE && !restart;
    w_in_xfer  = cen && din_valid && din_ready;
    w_out_free = !r_dout_valid || dout_ready;
    w_upd      = r_state == ST_UPD && w_out_free;
    w_diff     = {din[11], din} - {r_pred[11], r_pred};
    w_mag_in   = w_diff[12] ? ~w_diff[11:0] + 12'd1 : w_diff[11:0];
    w_thr      = r_state == ST_Q2 ? {1'b0, w_step} :
                 r_state == ST_Q1 ? {2'b0, w_step[10:1]} : {3'b0, w_step[10:2]};
    w_hit      = r_mag >= w_thr;
    // Reconstruction delta uses the truncated shifted steps, exactly as the decoder does.
    w_delta    = {4'b0, w_step[10:3]} + (r_bits[2] ? {1'b0, w_step} : 12'd0) +
                 (r_bits[1] ? {2'b0, w_step[10:1]} : 12'd0) + (r_bits[0] ? {3'b0, w_step[10:2]} : 12'd0);
    w_dext     = {2'b0, w_delta};
    w_pred_sum = {{2{r_pred[11]}}, r_pred} + (r_sign ? -w_dext : w_dext);
    w_pred_nx  = int'(w_pred_sum) < PCM_MIN ? 12'(PCM_MIN) :
                 int'(w_pred_sum) > PCM_MAX ? 12'(PCM_MAX) : w_pred_sum[11:0];
    w_idx_sum  = {1'b0, r_idx} + 7'(IDX_ADJ[r_bits]);
    w_idx_nx   = int'(w_idx_sum) < 0 ? 6'd0 : int'(w_idx_sum) > IDX_MAX ? 6'(IDX_MAX) : w_idx_sum[5:0];
  end
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: w_state_nx = w_in_xfer ? ST_Q2 : ST_IDLE;
      ST_Q2:   w_state_nx = ST_Q1;
      ST_Q1:   w_state_nx = ST_Q0;
      ST_Q0:   w_state_nx = ST_UPD;
      ST_UPD:  w_state_nx = w_out_free ? ST_IDLE : ST_UPD;
      default: w_state_nx = ST_IDLE;
    endcase
    if (restart) w_state_nx = ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pred       <= '0;
      r_idx        <= 6'(INIT_IDX);
      r_mag        <= '0;
      r_sign       <= 1'b0;
      r_bits       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (cen) begin
      r_state <= w_state_nx;
      if (r_dout_valid && dout_ready) r_dout_valid <= 1'b0;
      // Restart drops any in-flight sample but leaves a pending code in place.
      if (restart) begin
        r_pred <= '0;
        r_idx  <= 6'(INIT_IDX);
      end else if (w_in_xfer) begin
        r_sign <= w_diff[12];
        r_mag  <= w_mag_in;
        r_bits <= '0;
      end else if (r_state inside {ST_Q2, ST_Q1, ST_Q0}) begin
        r_bits <= {r_bits[1:0], w_hit};
        if (w_hit) r_mag <= r_mag - w_thr;
      end else if (w_upd) begin
        r_pred       <= w_pred_nx;
        r_idx        <= w_idx_nx;
        r_dout       <= {r_sign, r_bits};
        r_dout_valid <= 1'b1;
      end
    end
  end
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
`ifdef JT5205_ENC_RECON_EN
  assign recon    = r_pred;
  assign step_idx = r_idx;
`endif
endmodule

// File: tb/tb_jt5205_enc.sv
// tb_jt5205_enc: scoreboard bench for jt5205_enc against a behavioural ADPCM model
module tb_jt5205_enc;
  logic clk = 1'b0, rst, cen, restart, din_valid, din_ready, dout_valid, dout_ready;
  logic [11:0] din;
  logic [3:0]  dout;
`ifdef JT5205_ENC_RECON_EN
  logic signed [11:0] recon;
  logic [5:0]         step_idx;
`endif
  typedef struct {logic [3:0] code; int pred; int idx;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0, m_pred = 0, m_idx = 0;
  logic cen_rand = 1'b0;
  int tbl [0:48] = '{16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60, 66, 73, 80, 88, 97,
                     107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371, 408, 449,
                     494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552};
  int adj [0:7] = '{-1, -1, -1, -1, 2, 4, 6, 8};
  always #5 clk = ~clk;
  jt5205_enc #(.INIT_IDX(0)) dut (
    .clk(clk), .rst(rst), .cen(cen), .restart(restart), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
`ifdef JT5205_ENC_RECON_EN
    , .recon(recon), .step_idx(step_idx)
`endif
  );
  function automatic exp_t model(input int d);
    exp_t e;
    int diff, mag, st, delta, code;
    diff = d - m_pred;
    st = tbl[m_idx];
    mag = diff < 0 ? -diff : diff;
    code = diff < 0 ? 8 : 0;
    delta = st / 8;
    if (mag >= st) begin code += 4; mag -= st; delta += st; end
    if (mag >= st / 2) begin code += 2; mag -= st / 2; delta += st / 2; end
    if (mag >= st / 4) begin code += 1; delta += st / 4; end
    m_pred = diff < 0 ? m_pred - delta : m_pred + delta;
    if (m_pred < -2048) m_pred = -2048;
    if (m_pred > 2047) m_pred = 2047;
    m_idx += adj[code % 8];
    if (m_idx < 0) m_idx = 0;
    if (m_idx > 48) m_idx = 48;
    e.code = 4'(code);
    e.pred = m_pred;
    e.idx = m_idx;
    return e;
  endfunction
  function automatic exp_t take();
    exp_t e;
    e.code = 4'bx;
    e.pred = 99999;
    e.idx = 99;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cen_rand) cen = 1'($urandom_range(0, 1));
  endtask
  task automatic do_reset();
    rst = 1'b1; restart = 1'b0; din_valid = 1'b0; cen = 1'b1; dout_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    m_pred = 0; m_idx = 0;
    sb.delete();
  endtask
  task automatic send(input int d);
    int n = 0;
    din = 12'(d);
    din_valid = 1'b1;
    while (!(din_ready && cen) && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout din_ready=%0b required 1", din_ready);
    end else begin
      sb.push_back(model(d));
      acc_cyc = cyc;
      tick();
    end
    din_valid = 1'b0;
  endtask
  task automatic wait_out(output int n);
    int t = 0;
    logic c;
    n = 0;
    do begin c = cen; tick(); t++; if (c) n++; end while (!dout_valid && t < 500);
    if (!dout_valid) begin
      checks++; failures++;
      $display("FAIL out_timeout dout_valid=%0b required 1", dout_valid);
    end
  endtask
  task automatic test_reset();
    int n;
    do_reset();
    dout_ready = 1'b0;
    send(100);
    wait_out(n);
    send(200);
    tick();
    cen = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%0b exp=0", dout_valid); end
    checks++; if (dout !== 4'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready got=%0b exp=1", din_ready); end
`ifdef JT5205_ENC_RECON_EN
    checks++; if (recon !== 12'sd0 || step_idx !== 6'd0) begin failures++; $display("FAIL reset_recon got=%0d/%0d exp=0/0", recon, step_idx); end
`endif
    cen = 1'b1; dout_ready = 1'b1;
    sb.delete();
  endtask
  task automatic test_single();
    int n;
    exp_t e;
    do_reset();
    send(100);
    wait_out(n);
    e = take();
    checks++; if (n !== 4) begin failures++; $display("FAIL single_latency got=%0d exp=4", n); end
    checks++; if (dout !== 4'h7) begin failures++; $display("FAIL single_code got=%h exp=7", dout); end
    checks++; if (dout !== e.code) begin failures++; $display("FAIL single_model got=%h exp=%h", dout, e.code); end
`ifdef JT5205_ENC_RECON_EN
    checks++; if (recon !== 12'sd30 || step_idx !== 6'd8) begin failures++; $display("FAIL single_recon got=%0d/%0d exp=30/8", recon, step_idx); end
`endif
  endtask
  task automatic test_zero();
    int n;
    exp_t e;
    do_reset();
    send(0);
    wait_out(n);
    e = take();
    checks++; if (dout_valid !== 1'b1 || dout !== 4'h0) begin failures++; $display("FAIL zero_code got=%h/%0b exp=0/1", dout, dout_valid); end
    checks++; if (e.pred !== 2 || e.idx !== 0 || e.code !== 4'h0) begin failures++; $display("FAIL zero_model got=%0d/%0d exp=2/0", e.pred, e.idx); end
`ifdef JT5205_ENC_RECON_EN
    checks++; if (recon !== 12'sd2 || step_idx !== 6'd0) begin failures++; $display("FAIL zero_recon got=%0d/%0d exp=2/0", recon, step_idx); end
`endif
  endtask
  task automatic test_sat();
    int n;
    exp_t e;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      send(i < 40 ? -2048 : (i % 2 ? 2047 : -2048));
      wait_out(n);
      e = take();
      checks++; if (dout !== e.code) begin failures++; $display("FAIL sat_code i=%0d got=%h exp=%h", i, dout, e.code); end
`ifdef JT5205_ENC_RECON_EN
      checks++; if (recon !== 12'(e.pred) || step_idx !== 6'(e.idx)) begin failures++; $display("FAIL sat_recon i=%0d got=%0d/%0d exp=%0d/%0d", i, recon, step_idx, e.pred, e.idx); end
`endif
    end
  endtask
  task automatic test_sine();
    int n;
    exp_t e;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      send($rtoi(1500.0 * $sin(2.0 * 3.14159265358979 * k / 32.0)));
      wait_out(n);
      e = take();
      checks++; if (dout !== e.code) begin failures++; $display("FAIL sine_code k=%0d got=%h exp=%h", k, dout, e.code); end
`ifdef JT5205_ENC_RECON_EN
      checks++; if (recon !== 12'(e.pred)) begin failures++; $display("FAIL sine_recon k=%0d got=%0d exp=%0d", k, recon, e.pred); end
`endif
    end
  endtask
  task automatic test_back_to_back();
    int n, prev;
    exp_t e;
    do_reset();
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      send(int'($urandom_range(0, 4095)) - 2048);
      checks++; if (i > 0 && acc_cyc - prev !== 5) begin failures++; $display("FAIL b2b_interval i=%0d got=%0d exp=5", i, acc_cyc - prev); end
      prev = acc_cyc;
      wait_out(n);
      e = take();
      checks++; if (dout !== e.code) begin failures++; $display("FAIL b2b_code i=%0d got=%h exp=%h", i, dout, e.code); end
    end
  endtask
  task automatic test_backpressure();
    int n;
    exp_t a, b;
    do_reset();
    dout_ready = 1'b0;
    send(-700);
    wait_out(n);
    a = take();
    checks++; if (dout !== a.code) begin failures++; $display("FAIL bp_first got=%h exp=%h", dout, a.code); end
    send(900);
    repeat (3) tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (dout !== a.code || dout_valid !== 1'b1 || din_ready !== 1'b0) begin
        failures++; $display("FAIL bp_stall i=%0d got=%h/%0b/%0b exp=%h/1/0", i, dout, dout_valid, din_ready, a.code);
      end
    end
    dout_ready = 1'b1;
    tick();
    b = take();
    checks++; if (dout !== b.code || dout_valid !== 1'b1) begin failures++; $display("FAIL bp_replace got=%h/%0b exp=%h/1", dout, dout_valid, b.code); end
    tick();
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", dout_valid); end
  endtask
  task automatic test_cen();
    int n;
    exp_t e;
    do_reset();
    send(321);
    cen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (din_ready !== 1'b0 || dout_valid !== 1'b0) begin failures++; $display("FAIL cen_freeze i=%0d got=%0b/%0b exp=0/0", i, din_ready, dout_valid); end
    end
    cen = 1'b1;
    wait_out(n);
    e = take();
    checks++; if (n !== 4 || dout !== e.code) begin failures++; $display("FAIL cen_resume got=%0d/%h exp=4/%h", n, dout, e.code); end
    cen_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, 3000)) - 1500);
      wait_out(n);
      e = take();
      checks++; if (n !== 4 || dout !== e.code) begin failures++; $display("FAIL cen_burst i=%0d got=%0d/%h exp=4/%h", i, n, dout, e.code); end
    end
    cen_rand = 1'b0;
    cen = 1'b1;
  endtask
  task automatic test_restart();
    int n;
    logic seen;
    exp_t e;
    do_reset();
    send(100);
    tick();
    restart = 1'b1; din_valid = 1'b1; din = 12'd555;
    #1;
    checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL restart_ready got=%0b exp=0", din_ready); end
    tick();
    void'(sb.pop_back());
    m_pred = 0; m_idx = 0;
    tick();
    tick();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); seen |= dout_valid; end
    restart = 1'b0; din_valid = 1'b0;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL restart_discard got=%0b exp=0", seen); end
    send(100);
    wait_out(n);
    e = take();
    checks++; if (dout !== 4'h7 || dout !== e.code || n !== 4) begin failures++; $display("FAIL restart_again got=%h/%0d exp=7/4", dout, n); end
  endtask
  initial begin
    rst = 1'b1; cen = 1'b1; restart = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    test_reset();
    test_single();
    test_zero();
    test_sat();
    test_sine();
    test_back_to_back();
    test_backpressure();
    test_cen();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
